// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier controller.
// Drives an external 32-bit add/subtract stage one Booth step per cycle and
// returns the low 32 bits of the signed product plus an overflow flag.
// Optional feature macro: MULT_RESTART_EN (ctrl_MULT while busy restarts).
module booth_mult_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] adder_operandA,
    output logic [31:0] adder_operandB,
    output logic        adder_addOrSub,
    output logic        adder_skip,
    input  logic [31:0] adder_result,
    input  logic        adder_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic        g_q, g_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        sum_sign;
    logic [31:0] phi_sh;
    logic [31:0] plo_sh;
    logic        g_sh;
    logic        restart;

    assign adder_operandA = phi_q;
    assign adder_operandB = m_q;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

`ifdef MULT_RESTART_EN
    assign restart = ctrl_MULT;
`else
    assign restart = 1'b0;
`endif

    // Booth pair decode: adder controls only act while iterating
    always_comb begin
        adder_skip     = 1'b1;
        adder_addOrSub = 1'b0;
        if (state_q == BUSY) begin
            case ({plo_q[0], g_q})
                2'b01:   adder_skip = 1'b0;
                2'b10: begin
                    adder_skip     = 1'b0;
                    adder_addOrSub = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Arithmetic shift of {true sign, sum, P_lo, q}; sign corrected for overflow
    always_comb begin
        sum_sign = adder_result[31] ^ adder_overflow;
        phi_sh   = {sum_sign, adder_result[31:1]};
        plo_sh   = {adder_result[0], plo_q[31:1]};
        g_sh     = plo_q[0];
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        g_d      = g_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (ctrl_MULT) begin
                    state_d = BUSY;
                    m_d     = data_operandA;
                    phi_d   = '0;
                    plo_d   = data_operandB;
                    g_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (restart) begin
                    m_d   = data_operandA;
                    phi_d = '0;
                    plo_d = data_operandB;
                    g_d   = 1'b0;
                    cnt_d = '0;
                end else begin
                    phi_d = phi_sh;
                    plo_d = plo_sh;
                    g_d   = g_sh;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DONE;
                        result_d = plo_sh;
                        exc_d    = (phi_sh != {32{plo_sh[31]}});
                        rdy_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            phi_q    <= '0;
            plo_q    <= '0;
            g_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            g_q      <= g_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed testbench for booth_mult_seq with a behavioural add/subtract stage.
module tb_booth_mult_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] adder_operandA;
    logic [31:0] adder_operandB;
    logic        adder_addOrSub;
    logic        adder_skip;
    logic [31:0] adder_result;
    logic        adder_overflow;

    int n_vec  = 0;
    int n_fail = 0;

    booth_mult_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .adder_operandA (adder_operandA),
        .adder_operandB (adder_operandB),
        .adder_addOrSub (adder_addOrSub),
        .adder_skip     (adder_skip),
        .adder_result   (adder_result),
        .adder_overflow (adder_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared adder: skip passes A through, otherwise A+B or A-B with signed overflow
    always_comb begin
        adder_result   = adder_operandA;
        adder_overflow = 1'b0;
        if (!adder_skip) begin
            if (adder_addOrSub) begin
                adder_result   = adder_operandA - adder_operandB;
                adder_overflow = (adder_operandA[31] != adder_operandB[31]) &&
                                 (adder_result[31] != adder_operandA[31]);
            end else begin
                adder_result   = adder_operandA + adder_operandB;
                adder_overflow = (adder_operandA[31] == adder_operandB[31]) &&
                                 (adder_result[31] != adder_operandA[31]);
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1 ctrl_MULT = 1'b0;
    endtask

    // Start, then check RDY stays low through edge 31, pulses at 32, drops at 33
    task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_exc);
        int early;
        early = 0;
        start_op(a, b);
        for (int i = 1; i <= 31; i++) begin
            @(posedge clock);
            #1 if (data_resultRDY) early++;
        end
        n_vec++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL %s early_rdy: saw %0d early pulses, required 0", name, early);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (data_resultRDY !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rdy_edge32: got %b, required 1", name, data_resultRDY);
        end
        n_vec++;
        if (data_result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", name, data_result, exp_res);
        end
        n_vec++;
        if (data_exception !== exp_exc) begin
            n_fail++;
            $display("FAIL %s exception: got %b, required %b", name, data_exception, exp_exc);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (data_resultRDY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rdy_edge33: got %b, required 0", name, data_resultRDY);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        n_vec++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%b/%b, required 0/0/0",
                     data_result, data_exception, data_resultRDY);
        end
        n_vec++;
        if (adder_skip !== 1'b1 || adder_addOrSub !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_adder_ctl: got skip=%b sub=%b, required skip=1 sub=0",
                     adder_skip, adder_addOrSub);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_products();
        run_mult("3x5",     32'd3,          32'd5,          32'd15,         1'b0);
        run_mult("m7x6",    32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6,   1'b0);
        run_mult("m1xm1",   32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0);
        run_mult("max_x2",  32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b1);
        run_mult("min_min", 32'h80000000,   32'h80000000,   32'h00000000,   1'b1);
    endtask

    task automatic test_reset_mid_op();
        int rdy_seen;
        run_mult("pre_reset", 32'd7, 32'd11, 32'd77, 1'b0);
        start_op(32'd100, 32'd100);
        for (int i = 1; i <= 10; i++) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        n_vec++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %h/%b/%b, required 0/0/0",
                     data_result, data_exception, data_resultRDY);
        end
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1 if (data_resultRDY) rdy_seen++;
        end
        n_vec++;
        if (rdy_seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_rdy: saw %0d pulses, required 0", rdy_seen);
        end
        run_mult("4x4_after_reset", 32'd4, 32'd4, 32'd16, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_mult("b2b_first", 32'd12, 32'd12, 32'd144, 1'b0);
        // run_mult left us just after edge 33; rebuild the case with a start at edge 33
        start_op(32'd6, 32'd7);
        for (int i = 1; i <= 32; i++) @(posedge clock);
        #1;
        n_vec++;
        if (data_resultRDY !== 1'b1 || data_result !== 32'd42) begin
            n_fail++;
            $display("FAIL b2b_setup: got rdy=%b res=%h, required rdy=1 res=0000002a",
                     data_resultRDY, data_result);
        end
        @(negedge clock);
        data_operandA = 32'hFFFFFFFE;
        data_operandB = 32'd9;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1 ctrl_MULT = 1'b0;
        n_vec++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'd42) begin
            n_fail++;
            $display("FAIL b2b_hold: got rdy=%b res=%h, required rdy=0 res=0000002a",
                     data_resultRDY, data_result);
        end
        for (int i = 1; i <= 32; i++) @(posedge clock);
        #1;
        n_vec++;
        if (data_resultRDY !== 1'b1 || data_result !== 32'hFFFFFFEE) begin
            n_fail++;
            $display("FAIL b2b_second: got rdy=%b res=%h, required rdy=1 res=ffffffee",
                     data_resultRDY, data_result);
        end
        @(posedge clock);
    endtask

    task automatic test_busy_start();
        int          rdy_cnt;
        int          rdy_edge;
        logic [31:0] res_at_rdy;
        int          exp_edge;
        logic [31:0] exp_res;
`ifdef MULT_RESTART_EN
        exp_edge = 38;
        exp_res  = 32'd81;
`else
        exp_edge = 32;
        exp_res  = 32'd6;
`endif
        rdy_cnt    = 0;
        rdy_edge   = -1;
        res_at_rdy = '0;
        start_op(32'd2, 32'd3);
        for (int e = 1; e <= 45; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                rdy_cnt++;
                rdy_edge   = e;
                res_at_rdy = data_result;
            end
            if (e == 5) begin
                data_operandA = 32'd9;
                data_operandB = 32'd9;
                ctrl_MULT     = 1'b1;
            end
            if (e == 6) ctrl_MULT = 1'b0;
        end
        n_vec++;
        if (rdy_cnt !== 1) begin
            n_fail++;
            $display("FAIL busy_start_rdy_count: got %0d, required 1", rdy_cnt);
        end
        n_vec++;
        if (rdy_edge !== exp_edge) begin
            n_fail++;
            $display("FAIL busy_start_rdy_edge: got %0d, required %0d", rdy_edge, exp_edge);
        end
        n_vec++;
        if (res_at_rdy !== exp_res) begin
            n_fail++;
            $display("FAIL busy_start_result: got %h, required %h", res_at_rdy, exp_res);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_reset_mid_op();
        test_back_to_back();
        test_busy_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
